pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register: the next-generation replacement for the fixed-width stage latches between pipeline stages. It carries an arbitrary-width payload with a valid bit and supports a global enable, a synchronous flush (bubble insert), and a programmable multi-cycle hold for long-latency units such as the iterative multiplier. It also keeps a saturating stall-cycle counter for performance debug. One instance sits at each stage boundary (IF/ID through MEM/WB).

---
 rtl/pipe_stage_reg.sv | 113 +++++++++++
 tb/tb_pipe_stage_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: inter-stage pipeline register with enable, flush (bubble
// insert), programmable multi-cycle hold and a saturating stall counter.
// One instance sits at each stage boundary; payload and valid always move
// together so a stage never sees half an update.
module pipe_stage_reg #(
  parameter int DW       = 72,
  parameter int CNT_W    = 6,
  parameter int HOLD_DEF = 32,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_reg,
  input  logic              flush,
  input  logic              valid_in,
  input  logic [DW-1:0]     data_in,
  input  logic              hold_req,
  input  logic [CNT_W-1:0]  hold_len,
  output logic              valid_out,
  output logic [DW-1:0]     data_out,
  output logic              busy,
  output logic [PERF_W-1:0] stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0]  HOLD_DEF_C = CNT_W'(HOLD_DEF);
  localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
  localparam logic [PERF_W-1:0] STALL_MAX  = '1;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] hold_l;
  logic             capture;
  logic             clear;
  logic             stall_inc;

  // A zero hold length is shorthand for the default hold length.
  always_comb begin
    hold_l = (hold_len == '0) ? HOLD_DEF_C : hold_len;
  end

  // Next-state logic: flush beats everything, an active hold ignores new
  // requests, and a capture only happens when no hold suppresses this edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    capture   = 1'b0;
    clear     = 1'b0;
    stall_inc = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
      clear     = 1'b1;
    end else if (state == HOLD) begin
      cnt_nxt   = cnt - ONE_C;
      stall_inc = 1'b1;
      if (cnt == ONE_C) begin
        state_nxt = IDLE;
      end
    end else if (hold_req) begin
      // The edge that samples the request is the first suppressed edge,
      // so only L-1 further edges remain; a length of 1 never enters HOLD.
      cnt_nxt   = hold_l - ONE_C;
      stall_inc = 1'b1;
      if (hold_l > ONE_C) begin
        state_nxt = HOLD;
      end
    end else if (en_reg) begin
      capture = 1'b1;
    end
  end

  // Busy warns the upstream stage that the coming edge will not capture.
  assign busy = (state == HOLD) | ((state == IDLE) & hold_req & ~flush);

  // State and hold counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Payload and valid register; a flush loads a bubble.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (capture) begin
      valid_out <= valid_in;
      data_out  <= data_in;
    end
  end

  // Saturating count of hold-suppressed edges; sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall_inc && (stall_cnt != STALL_MAX)) begin
      stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// A second instance with a 4-bit stall counter shares the stimulus so the
// saturation behaviour can be observed in a short run.
module tb_pipe_stage_reg;

  localparam int DW = 72;

  logic          clk;
  logic          rst;
  logic          en_reg;
  logic          flush;
  logic          valid_in;
  logic [DW-1:0] data_in;
  logic          hold_req;
  logic [5:0]    hold_len;

  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          busy;
  logic [15:0]   stall_cnt;

  logic          s_valid_out;
  logic [7:0]    s_data_out;
  logic          s_busy;
  logic [3:0]    s_stall_cnt;

  int total;
  int bad;

  pipe_stage_reg #(.DW(DW), .CNT_W(6), .HOLD_DEF(32), .PERF_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .en_reg    (en_reg),
    .flush     (flush),
    .valid_in  (valid_in),
    .data_in   (data_in),
    .hold_req  (hold_req),
    .hold_len  (hold_len),
    .valid_out (valid_out),
    .data_out  (data_out),
    .busy      (busy),
    .stall_cnt (stall_cnt)
  );

  pipe_stage_reg #(.DW(8), .CNT_W(6), .HOLD_DEF(32), .PERF_W(4)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .en_reg    (en_reg),
    .flush     (flush),
    .valid_in  (valid_in),
    .data_in   (data_in[7:0]),
    .hold_req  (hold_req),
    .hold_len  (hold_len),
    .valid_out (s_valid_out),
    .data_out  (s_data_out),
    .busy      (s_busy),
    .stall_cnt (s_stall_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [DW-1:0] got,
                             input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after an edge; the #1 lets busy settle.
  task automatic applyStimulus(input logic r, input logic f, input logic en,
                               input logic hr, input logic [5:0] hl,
                               input logic v, input logic [DW-1:0] d);
    rst      = r;
    flush    = f;
    en_reg   = en;
    hold_req = hr;
    hold_len = hl;
    valid_in = v;
    data_in  = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    // Reset for two edges.
    applyStimulus(1, 0, 0, 0, 0, 0, '0);
    tick();
    tick();
    checkOutput("rst_valid", valid_out, 0);
    checkOutput("rst_data",  data_out,  0);
    checkOutput("rst_stall", stall_cnt, 0);
    checkOutput("rst_busy0", busy,      0);
    applyStimulus(1, 0, 0, 1, 0, 0, '0);
    checkOutput("rst_busy_req", busy, 1);
    applyStimulus(1, 1, 0, 1, 0, 0, '0);
    checkOutput("rst_busy_flush", busy, 0);

    // Basic capture, hold with en_reg low, then a full-width pattern.
    applyStimulus(0, 0, 1, 0, 0, 1, 72'hA5);
    tick();
    checkOutput("cap_valid", valid_out, 1);
    checkOutput("cap_data",  data_out,  72'hA5);
    applyStimulus(0, 0, 0, 0, 0, 0, 72'h5A);
    tick();
    checkOutput("noen_data",  data_out,  72'hA5);
    checkOutput("noen_valid", valid_out, 1);
    applyStimulus(0, 0, 1, 0, 0, 1, 72'hC3_0123_4567_89AB_CDEF);
    tick();
    checkOutput("wide_data", data_out, 72'hC3_0123_4567_89AB_CDEF);
    applyStimulus(0, 0, 1, 0, 0, 1, 72'hA5);
    tick();
    checkOutput("cap2_data", data_out, 72'hA5);

    // Default hold: 32 suppressed edges while data_in toggles.
    applyStimulus(0, 0, 1, 1, 0, 1, 72'h100);
    for (int i = 1; i <= 32; i++) begin
      if (i > 1) applyStimulus(0, 0, 1, 0, 0, 1, DW'(256 + i));
      checkOutput($sformatf("dh_busy%0d", i), busy, 1);
      tick();
      checkOutput($sformatf("dh_data%0d", i), data_out, 72'hA5);
    end
    checkOutput("dh_stall", stall_cnt, 32);
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h77);
    checkOutput("dh_busy_end", busy, 0);
    tick();
    checkOutput("dh_resume", data_out, 72'h77);

    // Hold of length 1: one suppressed edge, never enters HOLD.
    applyStimulus(0, 0, 1, 1, 1, 1, 72'h11);
    checkOutput("h1_busy", busy, 1);
    tick();
    checkOutput("h1_data", data_out, 72'h77);
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h12);
    checkOutput("h1_idle", busy, 0);
    tick();
    checkOutput("h1_resume", data_out, 72'h12);
    checkOutput("h1_stall", stall_cnt, 33);

    // Hold of length 3.
    applyStimulus(0, 0, 1, 1, 3, 1, 72'h21);
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) applyStimulus(0, 0, 1, 0, 0, 1, DW'(32 + i));
      checkOutput($sformatf("h3_busy%0d", i), busy, 1);
      tick();
      checkOutput($sformatf("h3_data%0d", i), data_out, 72'h12);
    end
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h24);
    checkOutput("h3_busy_end", busy, 0);
    tick();
    checkOutput("h3_resume", data_out, 72'h24);
    checkOutput("h3_stall", stall_cnt, 36);

    // Flush on the 4th cycle of a 10-edge hold.
    applyStimulus(0, 0, 1, 1, 10, 1, 72'h31);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h32);
    tick();
    tick();
    applyStimulus(0, 1, 1, 0, 0, 1, 72'h33);
    checkOutput("fl_busy_hold", busy, 1);
    tick();
    checkOutput("fl_valid", valid_out, 0);
    checkOutput("fl_data",  data_out,  0);
    checkOutput("fl_stall", stall_cnt, 39);
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h44);
    checkOutput("fl_busy_after", busy, 0);
    tick();
    checkOutput("fl_resume_d", data_out,  72'h44);
    checkOutput("fl_resume_v", valid_out, 1);

    // Reset in the middle of a hold.
    applyStimulus(0, 0, 1, 1, 5, 1, 72'h45);
    tick();
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h46);
    tick();
    checkOutput("rm_busy_hold", busy, 1);
    applyStimulus(1, 0, 1, 0, 0, 1, 72'h47);
    tick();
    checkOutput("rm_valid", valid_out, 0);
    checkOutput("rm_data",  data_out,  0);
    checkOutput("rm_stall", stall_cnt, 0);
    checkOutput("rm_busy",  busy,      0);

    // Reset, flush and hold_req together: reset wins.
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h55);
    tick();
    checkOutput("rf_pre", data_out, 72'h55);
    applyStimulus(1, 1, 1, 1, 4, 1, 72'h56);
    tick();
    checkOutput("rf_valid", valid_out, 0);
    checkOutput("rf_data",  data_out,  0);
    checkOutput("rf_stall", stall_cnt, 0);
    checkOutput("rf_busy_flush", busy, 0);
    applyStimulus(1, 0, 1, 1, 4, 1, 72'h56);
    checkOutput("rf_busy_idle", busy, 1);

    // Three back-to-back holds of 6 with hold_req held high: 18 suppressed
    // edges; the 4-bit counter saturates at 15.
    applyStimulus(0, 0, 1, 1, 6, 1, 72'h60);
    for (int i = 1; i <= 18; i++) begin
      checkOutput($sformatf("bb_busy%0d", i), busy, 1);
      tick();
      checkOutput($sformatf("bb_data%0d", i), data_out, 0);
      checkOutput($sformatf("bb_sat%0d", i), s_stall_cnt, (i < 15) ? i : 15);
    end
    checkOutput("bb_stall", stall_cnt, 18);
    applyStimulus(0, 0, 1, 0, 0, 1, 72'h66);
    checkOutput("bb_busy_end", busy, 0);
    tick();
    checkOutput("bb_resume", data_out, 72'h66);
    checkOutput("bb_sat_data", s_data_out, 8'h66);
    checkOutput("bb_sat_final", s_stall_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
